// File: rtl/lod_12_pre.sv
// Leading-one predictor for the 12-bit sum of two 11-bit unsigned operands.
// The candidate position comes from a priority encode of a|b. A flat
// sum-of-products carry term then decides whether the sum's leading one
// moves up one bit. The result is registered, so latency is one cycle.
module lod_12_pre (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] a,
  input  logic [10:0] b,
  output logic [3:0]  c,
  output logic        v
);

  // Generate, transmit and "either set" vectors. Bit 0 can never propagate an
  // incoming carry, so transmit starts at bit 1.
  logic [10:0] w_p;
  logic [10:0] w_g;
  logic [10:1] w_t;

  assign w_p = a | b;
  assign w_g = a & b;
  assign w_t = a[10:1] ^ b[10:1];

  // Carry out of bit i is the OR, over all j <= i, of g[j] AND t[j+1..i].
  // Each term is evaluated independently, so there is no ripple through
  // lower carries.
  function automatic logic f_carry_out(input logic [10:0] g, input logic [10:1] t, input int i);
    logic res;
    logic prop;
    res = 1'b0;
    for (int j = 0; j <= 10; j++) begin
      prop = (j <= i);
      for (int k = 1; k <= 10; k++) begin
        if (k > j && k <= i) prop = prop & t[k];
      end
      res = res | (prop & g[j]);
    end
    return res;
  endfunction

  logic [10:0] w_cy;

  genvar gi;
  generate
    for (gi = 0; gi < 11; gi++) begin : g_carry
      assign w_cy[gi] = f_carry_out(w_g, w_t, gi);
    end
  endgenerate

  // Priority encoder: index of the most significant set bit of a|b.
  logic [3:0] w_lead;
  logic       w_pv;

  // Later (higher) bits overwrite earlier ones, leaving the top set index.
  always_comb begin
    w_lead = 4'd0;
    for (int i = 0; i < 11; i++) begin
      if (w_p[i]) w_lead = 4'(i);
    end
  end

  assign w_pv = |w_p;

  // Select the carry out of the leading position. It pushes the sum's MSB
  // from p up to p+1.
  logic w_carry;

  always_comb begin
    w_carry = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (w_lead == 4'(i)) w_carry = w_cy[i];
    end
  end

  // A zero sum forces index 0. Otherwise the result is p or p+1 (at most 11).
  logic [3:0] w_c;
  assign w_c = w_pv ? (w_lead + {3'b000, w_carry}) : 4'd0;

  logic [3:0] r_c;
  logic       r_v;

  // Output register; asynchronous reset clears any in-flight result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c <= 4'd0;
      r_v <= 1'b0;
    end else begin
      r_c <= w_c;
      r_v <= w_pv;
    end
  end

  assign c = r_c;
  assign v = r_v;

endmodule

// File: tb/tb_lod_12_pre.sv
// Scoreboard bench for lod_12_pre. Stimulus pushes expected results computed
// from the MSB of the arithmetic sum. The monitor pops and compares one cycle
// after each applied operand pair.
module tb_lod_12_pre;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] a;
  logic [10:0] b;
  logic [3:0]  c;
  logic        v;

  lod_12_pre dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .c   (c),
    .v   (v)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] a;
    logic [10:0] b;
    logic [3:0]  c;
    logic        v;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  // Reference: the leading-one index of s is ceil(log2(s+1)) - 1.
  function automatic exp_t model(input logic [10:0] ia, input logic [10:0] ib);
    exp_t e;
    int   s;
    s    = int'(ia) + int'(ib);
    e.a  = ia;
    e.b  = ib;
    e.v  = (s != 0);
    e.c  = (s == 0) ? 4'd0 : 4'($clog2(s + 1) - 1);
    return e;
  endfunction

  task automatic drive(input logic [10:0] ia, input logic [10:0] ib);
    @(negedge clk);
    a = ia;
    b = ib;
    q.push_back(model(ia, ib));
  endtask

  // Monitor: the pair applied before this edge is popped and checked after the edge.
  always @(posedge clk) begin
    if (!rst && q.size() > 0) begin
      mon_e = q.pop_front();
      #1;
      $display("txn a=%h b=%h -> c=%0d v=%0d (exp c=%0d v=%0d)", mon_e.a, mon_e.b, c, v, mon_e.c, mon_e.v);
      chk("c_index", int'(c), int'(mon_e.c));
      chk("v_flag", int'(v), int'(mon_e.v));
      chk("c_range", int'(c <= 4'd11), 1);
    end
  end

  logic [10:0] ra;
  logic [10:0] rb;
  int          sh;

  initial begin
    rst = 1'b1;
    a   = 11'h000;
    b   = 11'h000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_c", int'(c), 0);
    chk("reset_v", int'(v), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed boundary cases.
    drive(11'h000, 11'h000);
    drive(11'h001, 11'h000);
    drive(11'h400, 11'h3FF);
    drive(11'h400, 11'h400);
    drive(11'h7FF, 11'h7FF);
    drive(11'h0FF, 11'h001);
    drive(11'h000, 11'h001);
    drive(11'h7FF, 11'h001);

    // Power-of-two edges at every position.
    for (int k = 0; k < 11; k++) begin
      ra = 11'((1 << k) - 1);
      drive(ra, 11'h001);
      drive(11'(1 << k), ra);
      drive(11'(1 << k), 11'(1 << k));
    end

    // Asynchronous reset mid-stream: outputs clear at once, no stale data after release.
    drive(11'h400, 11'h400);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_c", int'(c), 0);
    chk("midrst_v", int'(v), 0);
    a = 11'h000;
    b = 11'h000;
    @(posedge clk);
    #1;
    chk("hold_rst_v", int'(v), 0);
    @(negedge clk);
    rst = 1'b0;
    q.push_back(model(11'h000, 11'h000));
    drive(11'h0FF, 11'h001);

    // Randomised mix: full range, carry-free, carry chains, small magnitudes.
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0: begin
          ra = 11'($urandom);
          rb = 11'($urandom);
        end
        1: begin
          ra = 11'($urandom);
          rb = ~ra & 11'($urandom);
        end
        2: begin
          sh = $urandom_range(0, 10);
          ra = 11'((1 << sh) - 1) & ~11'($urandom_range(0, 3));
          rb = 11'($urandom_range(0, 7));
        end
        default: begin
          ra = 11'($urandom) >> $urandom_range(0, 11);
          rb = 11'($urandom) >> $urandom_range(0, 11);
        end
      endcase
      drive(ra, rb);
    end

    repeat (3) @(negedge clk);
    chk("queue_drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
